// File: rtl/wb_regfile_commit.sv
// Writeback/commit stage: picks the W-stage result, commits it to a 32-entry register file,
// and serves two decode read ports with same-cycle write-to-read bypass, a display latch and a commit counter.
module wb_regfile_commit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemtoRegW,
  input  logic              RegWriteW,
  input  logic [DATA_W-1:0] MemReadDataW,
  input  logic [DATA_W-1:0] ALUResultW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0] PCPlus4W,
  input  logic              jalW,
  input  logic              DisplayW,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] ResultW,
  output logic [DATA_W-1:0] DisplayValue,
  output logic [DATA_W-1:0] CommitCount
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] displayValue_q, displayValue_d;
  logic [DATA_W-1:0] commitCount_q, commitCount_d;
  logic [ADDR_W-1:0] destW;
  logic              writeEn;

  // jal overrides both the value and the destination of the W-stage write
  assign ResultW = jalW ? PCPlus4W : (MemtoRegW ? MemReadDataW : ALUResultW);
  assign destW   = jalW ? LINK_IDX : WriteRegW;
  assign writeEn = RegWriteW && (destW != '0) && !Reset;

  always_comb begin
    displayValue_d = displayValue_q;
    commitCount_d  = commitCount_q;
    if (DisplayW) displayValue_d = ResultW;
    if (writeEn)  commitCount_d  = commitCount_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      displayValue_q <= '0;
      commitCount_q  <= '0;
    end else begin
      if (writeEn) regs_q[destW] <= ResultW;
      displayValue_q <= displayValue_d;
      commitCount_q  <= commitCount_d;
    end
  end

  // Write-first bypass lets decode see this cycle's commit before the array is updated
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (!Reset && ReadReg1 != '0)
      ReadData1 = (writeEn && destW == ReadReg1) ? ResultW : regs_q[ReadReg1];
    if (!Reset && ReadReg2 != '0)
      ReadData2 = (writeEn && destW == ReadReg2) ? ResultW : regs_q[ReadReg2];
  end

  assign DisplayValue = displayValue_q;
  assign CommitCount  = commitCount_q;

endmodule
